// File: rtl/rx_engine_fifo.sv
// UART receive engine: synchronised RX, mid-bit sampled frame FSM with
// false-start rejection, feeding a small receive FIFO popped by READS.
module rx_engine_fifo #(
    parameter int BAUD_W     = 19,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BAUD_W-1:0] BAUD_DECODE,
    input  logic              EIGHT,
    input  logic              PEN,
    input  logic              OHEL,
    input  logic              STOP2,
    input  logic              RX,
    input  logic              READS,
    output logic [7:0]        UART_RDATA,
    output logic              PERR,
    output logic              FERR,
    output logic              BRK,
    output logic              OVF,
    output logic              RX_RDY,
    output logic [LVL_W-1:0]  RX_LEVEL
);

    // state  | meaning
    // IDLE   | waiting for a falling edge on rx_s
    // START  | half period elapsed check of start bit (false-start reject)
    // DATA   | sampling data bits, LSB first
    // PARITY | sampling parity bit
    // STOP   | sampling one or two stop bits
    // PUSH   | one cycle, word written to the FIFO
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    state_t            state;
    logic              rx_m, rx_s, rx_prev;
    logic [BAUD_W-1:0] period, cnt;
    logic              eight_l, pen_l, ohel_l, stop2_l;
    logic [2:0]        bit_idx;
    logic              stop_idx;
    logic              all_low;
    logic [7:0]        data;
    logic              perr, ferr, brk;
    logic              expire;

    assign expire = (cnt == BAUD_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rx_m     <= 1'b0;
            rx_s     <= 1'b0;
            rx_prev  <= 1'b0;
            period   <= '0;
            cnt      <= '0;
            eight_l  <= 1'b0;
            pen_l    <= 1'b0;
            ohel_l   <= 1'b0;
            stop2_l  <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            all_low  <= 1'b0;
            data     <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            brk      <= 1'b0;
        end else begin
            rx_m    <= RX;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
            case (state)
                IDLE: begin
                    // rx_prev resets low, so the line must be seen high first
                    if (rx_prev && !rx_s) begin
                        period   <= BAUD_DECODE;
                        cnt      <= BAUD_DECODE >> 1;
                        eight_l  <= EIGHT;
                        pen_l    <= PEN;
                        ohel_l   <= OHEL;
                        stop2_l  <= STOP2;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        all_low  <= 1'b1;
                        data     <= '0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        brk      <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (!expire) begin
                        cnt <= cnt - BAUD_W'(1);
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= period;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (!expire) begin
                        cnt <= cnt - BAUD_W'(1);
                    end else begin
                        cnt           <= period;
                        data[bit_idx] <= rx_s;
                        all_low       <= all_low & ~rx_s;
                        if (bit_idx == (eight_l ? 3'd7 : 3'd6))
                            state <= pen_l ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    if (!expire) begin
                        cnt <= cnt - BAUD_W'(1);
                    end else begin
                        cnt     <= period;
                        perr    <= rx_s ^ (^data) ^ ohel_l;
                        all_low <= all_low & ~rx_s;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (!expire) begin
                        cnt <= cnt - BAUD_W'(1);
                    end else begin
                        cnt <= period;
                        if (!rx_s) ferr <= 1'b1;
                        // break: everything up to and including stop 1 low
                        if (!stop_idx && !rx_s && all_low) begin
                            brk  <= 1'b1;
                            perr <= 1'b0;
                        end
                        if (stop_idx || !stop2_l) state <= PUSH;
                        else stop_idx <= 1'b1;
                    end
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [10:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count;
    logic             ovf;
    logic             push, full, do_pop, do_push;
    logic [10:0]      head;

    assign push    = (state == PUSH);
    assign full    = (count == FULL_LVL);
    assign do_pop  = READS && (count != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
            if (do_pop)            ovf <= 1'b0;
            else if (push && full) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= {brk, ferr, perr, data};
    end

    // storage is not reset, so the head is masked while empty
    assign head       = mem[rd_ptr];
    assign RX_RDY     = (count != '0);
    assign RX_LEVEL   = count;
    assign OVF        = ovf;
    assign UART_RDATA = RX_RDY ? head[7:0] : 8'h00;
    assign PERR       = RX_RDY & head[8];
    assign FERR       = RX_RDY & head[9];
    assign BRK        = RX_RDY & head[10];

endmodule

// File: tb/tb_rx_engine_fifo.sv
// Bench for rx_engine_fifo: frame-level reference model feeds an expected-word
// queue; a monitor pops and compares on every READS.
`timescale 1ns/1ps
module tb_rx_engine_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] BAUD_DECODE;
    logic        EIGHT, PEN, OHEL, STOP2, RX, READS;
    logic [7:0]  UART_RDATA;
    logic        PERR, FERR, BRK, OVF, RX_RDY;
    logic [2:0]  RX_LEVEL;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          P;
    logic [10:0] exp_q[$];
    bit          model_ovf;

    rx_engine_fifo #(.BAUD_W(19), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .BAUD_DECODE(BAUD_DECODE), .EIGHT(EIGHT),
        .PEN(PEN), .OHEL(OHEL), .STOP2(STOP2), .RX(RX), .READS(READS),
        .UART_RDATA(UART_RDATA), .PERR(PERR), .FERR(FERR), .BRK(BRK),
        .OVF(OVF), .RX_RDY(RX_RDY), .RX_LEVEL(RX_LEVEL)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // inputs change 2 ns after a rising edge; outputs are sampled on falling edges
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [10:0] expect_word(input logic [7:0] d, input bit e8,
            input bit pen, input bit ohel, input bit st2, input bit flip,
            input bit s1l, input bit s2l);
        logic [7:0] dm;
        bit pbit, perr, ferr, brk;
        dm   = e8 ? d : {1'b0, d[6:0]};
        pbit = (^dm) ^ ohel ^ flip;
        perr = pen && flip;
        ferr = s1l || (st2 && s2l);
        brk  = (dm == 8'h00) && (!pen || !pbit) && s1l;
        if (brk) return {3'b110, 8'h00};
        return {1'b0, ferr, perr, dm};
    endfunction

    task automatic model_push(input logic [10:0] w);
        if (exp_q.size() == DEPTH) model_ovf = 1'b1;
        else exp_q.push_back(w);
    endtask

    task automatic send(input logic [7:0] d, input bit flip, input bit s1l,
                        input bit s2l, input bit scramble);
        bit e8, pen, ohel, st2, pbit;
        int p;
        logic [7:0] dm;
        e8 = EIGHT; pen = PEN; ohel = OHEL; st2 = STOP2; p = int'(BAUD_DECODE);
        dm   = e8 ? d : {1'b0, d[6:0]};
        pbit = (^dm) ^ ohel ^ flip;
        RX = 1'b0;
        wait_cycles(p);
        if (scramble) begin
            EIGHT = 1'($urandom); PEN = 1'($urandom);
            OHEL = 1'($urandom); STOP2 = 1'($urandom);
            BAUD_DECODE = 19'($urandom_range(4, 200));
        end
        for (int i = 0; i < (e8 ? 8 : 7); i++) begin
            RX = dm[i];
            wait_cycles(p);
        end
        if (pen) begin RX = pbit; wait_cycles(p); end
        RX = !s1l; wait_cycles(p);
        if (st2) begin RX = !s2l; wait_cycles(p); end
        RX = 1'b1; wait_cycles(p);
        model_push(expect_word(d, e8, pen, ohel, st2, flip, s1l, s2l));
    endtask

    task automatic pop();
        READS = 1'b1; wait_cycles(1);
        READS = 1'b0; wait_cycles(1);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"}, 32'(RX_LEVEL), exp_q.size());
        check({tag, "_rdy"}, 32'(RX_RDY), 32'(exp_q.size() != 0));
        check({tag, "_ovf"}, 32'(OVF), 32'(model_ovf));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdata"}, 32'(UART_RDATA), 0);
        check({tag, "_flags"}, 32'({PERR, FERR, BRK, OVF}), 0);
        check({tag, "_rdy"}, 32'(RX_RDY), 0);
        check({tag, "_level"}, 32'(RX_LEVEL), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && READS) begin
            if (exp_q.size() > 0) begin
                check("head", 32'({BRK, FERR, PERR, UART_RDATA}), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                model_ovf = 1'b0;
            end else begin
                check("empty_read_rdy", 32'(RX_RDY), 0);
            end
        end
    end

    initial begin
        logic [7:0] first;
        rst = 1'b1; RX = 1'b1; READS = 1'b0; P = 109; BAUD_DECODE = 19'(P);
        EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0; STOP2 = 1'b0; model_ovf = 1'b0;
        wait_cycles(3);
        check_reset("reset");
        rst = 1'b0;
        wait_cycles(5);

        // 8N1 basic frame
        send(8'hA5, 0, 0, 0, 0);
        check("a5_data", 32'(UART_RDATA), 32'h A5);
        check("a5_flags", 32'({PERR, FERR, BRK}), 0);
        check_status("a5");
        pop();
        check_status("a5_pop");

        // 7-bit odd parity, good then flipped
        EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b1;
        send(8'h41, 0, 0, 0, 0);
        check("par_ok_data", 32'(UART_RDATA), 32'h41);
        check("par_ok_perr", 32'(PERR), 0);
        pop();
        send(8'h41, 1, 0, 0, 0);
        check("par_bad_perr", 32'(PERR), 1);
        pop();

        // second stop bit low, then a false start and an empty read
        STOP2 = 1'b1;
        send(8'h3C, 0, 0, 1, 0);
        check("stop2_ferr", 32'(FERR), 1);
        check_status("stop2");
        pop();
        RX = 1'b0; wait_cycles(40);
        RX = 1'b1; wait_cycles(3 * P);
        check_status("false_start");
        pop();
        check_status("empty_read");

        // break: line low for 12 bit periods
        EIGHT = 1'b1; PEN = 1'b0; STOP2 = 1'b0;
        RX = 1'b0; wait_cycles(12 * P);
        RX = 1'b1; wait_cycles(2 * P);
        model_push(11'b110_0000_0000);
        check("brk_flags", 32'({BRK, FERR, UART_RDATA}), 32'h300);
        check_status("brk");
        pop();

        // overflow, then pop clears it
        first = 8'($urandom);
        send(first, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) send(8'($urandom), 0, 0, 0, 0);
        check_status("ovf_set");
        check("ovf_flag", 32'(OVF), 1);
        check("ovf_head", 32'(UART_RDATA), 32'(first));
        pop();
        check_status("ovf_clr");
        send(8'($urandom), 0, 0, 0, 0);
        check_status("refill");
        // READS lands on the PUSH cycle: sync (2) + detect (1) + 54 + 9*109 + 1
        fork
            send(8'h5A, 0, 0, 0, 0);
            begin
                wait_cycles(1038);
                READS = 1'b1; wait_cycles(1);
                READS = 1'b0;
            end
        join
        check_status("same_cycle");
        check("same_cycle_ovf", 32'(OVF), 0);
        while (exp_q.size() > 0) pop();

        // reset in the middle of data bit 2 with two words queued
        send(8'h11, 0, 0, 0, 0);
        send(8'h22, 0, 0, 0, 0);
        check_status("pre_reset");
        RX = 1'b0; wait_cycles(P);
        RX = 1'b1; wait_cycles(P);
        RX = 1'b0; wait_cycles(P);
        RX = 1'b1; wait_cycles(P / 2);
        rst = 1'b1; wait_cycles(1);
        rst = 1'b0;
        exp_q.delete(); model_ovf = 1'b0;
        check_reset("mid_reset");
        wait_cycles(3 * P);
        check_status("post_reset_idle");
        send(8'hC3, 0, 0, 0, 0);
        check("post_reset_data", 32'(UART_RDATA), 32'hC3);
        pop();

        // randomized frames, baud rates and mid-frame config changes
        for (int n = 0; n < 16; n++) begin
            BAUD_DECODE = 19'($urandom_range(16, 40));
            EIGHT = 1'($urandom); PEN = 1'($urandom);
            OHEL = 1'($urandom); STOP2 = 1'($urandom);
            send(8'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, 1'($urandom));
            check_status("rand");
            if ($urandom_range(0, 2) != 0) pop();
        end
        while (exp_q.size() > 0) pop();
        check_status("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/rx_engine_fifo.md
# rx_engine_fifo

Parametrised successor to the team's UART receive engine. Deserialises asynchronous RX frames (7 or 8 data bits, optional odd/even parity, 1 or 2 stop bits) using a programmable bit-period counter with mid-bit sampling and false-start rejection. Received words and their error flags go into a receive FIFO of parametrised depth. The block sits between the RX pad and the UART register interface, which pops words with READS.

## Interface
- BAUD_W, 19, width of BAUD_DECODE.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of RX_LEVEL.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- BAUD_DECODE  in  BAUD_W  clk cycles per bit period; valid ≥ 4; sampled at each start-bit detection.
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits.
- PEN  in  1  parity enable.
- OHEL  in  1  parity sense: 1 = odd, 0 = even.
- STOP2  in  1  1 = two stop bits checked.
- RX  in  1  asynchronous serial input, idle high.
- READS  in  1  one-cycle pop strobe for the FIFO head.
- UART_RDATA  out  8  head data; bit 7 = 0 in 7-bit mode.
- PERR  out  1  head word parity error.
- FERR  out  1  head word framing error.
- BRK  out  1  head word is a break.
- OVF  out  1  sticky overflow.
- RX_RDY  out  1  FIFO non-empty.
- RX_LEVEL  out  LVL_W  FIFO occupancy.

## Operation
- RX passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Frame FSM states: IDLE, START, DATA, PARITY, STOP, PUSH.
- IDLE: a 1→0 edge on rx_s latches BAUD_DECODE into the period register, loads the counter with period>>1, then goes to START.
- START: at count expiry, rx_s=1 is a false start and returns to IDLE with nothing pushed. rx_s=0 reloads the counter with the full period and goes to DATA.
- DATA: samples one bit per period expiry, LSB first, 7 or 8 bits. Then goes to PARITY if PEN, else STOP.
- PARITY: the expected parity bit = XOR(data bits) XOR OHEL. A mismatch sets perr.
- STOP: samples 1 stop bit, or 2 if STOP2. Any low stop sample sets ferr.
- Break: all data bits, the parity bit if enabled, and the first stop bit sampled low. This sets brk and ferr and stores data 0x00.
- PUSH: one cycle. Writes {brk, ferr, perr, data} to the FIFO, then returns to IDLE. A new falling edge is accepted from the next cycle.
- EIGHT, PEN, OHEL and STOP2 are latched at start detection. Mid-frame changes do not affect the current frame.
- FIFO: circular buffer with wrapping read/write pointers and an occupancy count.
  - READS with the FIFO empty is ignored.
  - PUSH with the FIFO full and no same-cycle READS drops the word and sets OVF.
  - PUSH and READS in the same cycle when full: both take effect, count unchanged, OVF not set.
- OVF clears on the first READS that actually pops. Reset also clears it.
- Reset mid-frame abandons the frame. FIFO empties. The FSM goes to IDLE and requires rx_s high before a new edge counts.

## Timing
- Reset values: UART_RDATA=0, PERR=FERR=BRK=OVF=0, RX_RDY=0, RX_LEVEL=0, FSM=IDLE.
- Start edge to first data sample = period>>1 + period cycles after the synchronised edge. Synchroniser adds 2 cycles.
- RX_RDY and RX_LEVEL update on the clk edge ending PUSH, which is 1 cycle after the last stop sample.
- Head outputs are combinational from FIFO storage at the read pointer. They change on the clk edge that registers READS.
- Counter arithmetic uses BAUD_W bits with no wrap. The counter reloads at 1 → expiry.

## Test plan
- clk 10 ns, BAUD_DECODE=109, EIGHT=1, PEN=0, STOP2=0. Send 0xA5 → RX_RDY=1, UART_RDATA=0xA5, PERR=FERR=BRK=0, RX_LEVEL=1. Pulse READS → RX_RDY=0.
- EIGHT=0, PEN=1, OHEL=1. Send 0x41 with correct odd parity → 0x41, PERR=0. Repeat with the parity bit flipped → PERR=1.
- STOP2=1, second stop bit driven low → FERR=1, word still pushed. RX low pulse of 40 cycles → no push (false start).
- RX held low for 12 bit periods, then high → one entry 0x00 with BRK=1 and FERR=1.
- FIFO_DEPTH=4: send 5 frames with no READS → RX_LEVEL=4, OVF=1, head = first frame. First READS → OVF=0, RX_LEVEL=3. Fill to 4 again, then assert READS in the same cycle as a PUSH → RX_LEVEL stays 4, OVF=0.
- Assert rst for 1 cycle mid-data-bit with 2 words queued → all outputs at reset values. The next clean frame is received correctly.
